// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised serial input, mid-bit sampling FSM with
// configurable word length, optional parity, 1/2 stop bits and break handling.
module uart_rx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sin,
   input  logic       parity_en,
   input  logic       even_odd_parity,
   input  logic [1:0] data_bit_len,
   input  logic       num_of_stop_bits,
   output logic [7:0] data_out,
   output logic       rx_valid,
   output logic       parity_err,
   output logic       frame_err,
   output logic       rx_busy
);

   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } state_t;

   function automatic logic parity_mismatch(input logic [7:0] data, input logic pbit,
                                            input logic odd);
      return ((^data) ^ pbit) != odd;
   endfunction

   logic          sin_meta_r;
   logic          sin_sync_r;
   logic [1:0]    flush_r;
   logic          idle_seen_r;
   state_t        state_r;
   logic [CW-1:0] cnt_r;
   logic [2:0]    bit_cnt_r;
   logic          stop_cnt_r;
   logic [7:0]    shift_r;
   logic          par_en_r;
   logic          odd_r;
   logic [1:0]    len_r;
   logic          two_stop_r;
   logic          ferr_acc_r;
   logic          perr_acc_r;

   logic tick_s;
   logic last_data_s;
   logic stop_low_s;

   assign tick_s      = (cnt_r == FULL_LAST);
   // Last data bit index is 4 + data_bit_len, i.e. {1, len}.
   assign last_data_s = (bit_cnt_r == {1'b1, len_r});
   assign stop_low_s  = ferr_acc_r | ~sin_sync_r;

   // Input synchroniser; flush_r marks when sin_sync_r reflects the real line after reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sin_meta_r <= 1'b1;
         sin_sync_r <= 1'b1;
         flush_r    <= 2'b00;
      end else begin
         sin_meta_r <= sin;
         sin_sync_r <= sin_meta_r;
         flush_r    <= {flush_r[0], 1'b1};
      end
   end

   // Receive FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idle_seen_r <= 1'b0;
         state_r     <= IDLE;
         cnt_r       <= CNT_ZERO;
         bit_cnt_r   <= 3'd0;
         stop_cnt_r  <= 1'b0;
         shift_r     <= 8'h00;
         par_en_r    <= 1'b0;
         odd_r       <= 1'b0;
         len_r       <= 2'b00;
         two_stop_r  <= 1'b0;
         ferr_acc_r  <= 1'b0;
         perr_acc_r  <= 1'b0;
         data_out    <= 8'h00;
         rx_valid    <= 1'b0;
         parity_err  <= 1'b0;
         frame_err   <= 1'b0;
         rx_busy     <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         // A start edge only counts once the line has been seen idle since reset.
         if (flush_r[1] && sin_sync_r) begin
            idle_seen_r <= 1'b1;
         end
         case (state_r)
            IDLE: begin
               cnt_r <= CNT_ZERO;
               if (!sin_sync_r && idle_seen_r) begin
                  state_r    <= START;
                  bit_cnt_r  <= 3'd0;
                  stop_cnt_r <= 1'b0;
                  shift_r    <= 8'h00;
                  par_en_r   <= parity_en;
                  odd_r      <= even_odd_parity;
                  len_r      <= data_bit_len;
                  two_stop_r <= num_of_stop_bits;
                  ferr_acc_r <= 1'b0;
                  perr_acc_r <= 1'b0;
                  rx_busy    <= 1'b1;
               end
            end
            START: begin
               if (cnt_r == HALF_LAST) begin
                  cnt_r <= CNT_ZERO;
                  if (sin_sync_r) begin
                     state_r <= IDLE;
                     rx_busy <= 1'b0;
                  end else begin
                     state_r <= DATA;
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            DATA: begin
               if (tick_s) begin
                  cnt_r              <= CNT_ZERO;
                  shift_r[bit_cnt_r] <= sin_sync_r;
                  bit_cnt_r          <= bit_cnt_r + 3'd1;
                  if (last_data_s) begin
                     state_r <= par_en_r ? PARITY : STOP;
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            PARITY: begin
               if (tick_s) begin
                  cnt_r      <= CNT_ZERO;
                  perr_acc_r <= parity_mismatch(shift_r, sin_sync_r, odd_r);
                  state_r    <= STOP;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            STOP: begin
               if (tick_s) begin
                  cnt_r <= CNT_ZERO;
                  if (two_stop_r && !stop_cnt_r) begin
                     stop_cnt_r <= 1'b1;
                     ferr_acc_r <= stop_low_s;
                  end else begin
                     rx_valid   <= 1'b1;
                     data_out   <= shift_r;
                     parity_err <= perr_acc_r;
                     frame_err  <= stop_low_s;
                     state_r    <= stop_low_s ? BREAK : IDLE;
                     rx_busy    <= stop_low_s;
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            BREAK: begin
               if (sin_sync_r) begin
                  state_r <= IDLE;
                  rx_busy <= 1'b0;
               end
            end
            default: begin
               state_r <= IDLE;
               rx_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected words, a monitor
// pops and compares on every rx_valid pulse.
module tb_uart_rx;

   localparam int CPB = 16;

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sin = 1'b1;
   logic       parity_en = 1'b0;
   logic       even_odd_parity = 1'b0;
   logic [1:0] data_bit_len = 2'b11;
   logic       num_of_stop_bits = 1'b0;
   logic [7:0] data_out;
   logic       rx_valid;
   logic       parity_err;
   logic       frame_err;
   logic       rx_busy;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t sb[$];
   int   vt[$];

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .sin              (sin),
      .parity_en        (parity_en),
      .even_odd_parity  (even_odd_parity),
      .data_bit_len     (data_bit_len),
      .num_of_stop_bits (num_of_stop_bits),
      .data_out         (data_out),
      .rx_valid         (rx_valid),
      .parity_err       (parity_err),
      .frame_err        (frame_err),
      .rx_busy          (rx_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic set_cfg(input logic pen, input logic odd, input logic [1:0] len,
                          input logic two);
      parity_en        = pen;
      even_odd_parity  = odd;
      data_bit_len     = len;
      num_of_stop_bits = two;
   endtask

   task automatic drive_bit(input logic b);
      @(negedge clk);
      sin = b;
      repeat (CPB - 1) @(negedge clk);
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      sin = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input int nbits, input logic pen,
                             input logic pbit, input int nstop, input logic stop1,
                             input logic stop2, input logic scramble);
      drive_bit(1'b0);
      for (int i = 0; i < nbits; i++) begin
         drive_bit(d[i]);
         if (scramble && i == 0) set_cfg(~parity_en, ~even_odd_parity, ~data_bit_len,
                                         ~num_of_stop_bits);
      end
      if (pen) drive_bit(pbit);
      drive_bit(stop1);
      if (nstop == 2) drive_bit(stop2);
   endtask

   task automatic push(input logic [7:0] d, input logic pe, input logic fe);
      exp_t e;
      e.d = d;
      e.pe = pe;
      e.fe = fe;
      sb.push_back(e);
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: got %0d pending frames, required 0", sb.size());
         sb.delete();
      end
   endtask

   // Monitor: compares every rx_valid pulse against the scoreboard head.
   initial begin
      logic prev_valid = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (rx_valid) begin
            vt.push_back(cyc);
            check("rx_valid_one_cycle", {7'd0, prev_valid}, 8'h00);
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rx_valid: got pulse with data_out=%h, required no pulse",
                        data_out);
            end else begin
               e = sb.pop_front();
               check("data_out", data_out, e.d);
               check("parity_err", {7'd0, parity_err}, {7'd0, e.pe});
               check("frame_err", {7'd0, frame_err}, {7'd0, e.fe});
            end
         end
         prev_valid = rx_valid;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no completion, required $finish before time limit");
      $fatal(1);
   end

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check("rst_data_out", data_out, 8'h00);
      check("rst_rx_valid", {7'd0, rx_valid}, 8'h00);
      check("rst_parity_err", {7'd0, parity_err}, 8'h00);
      check("rst_frame_err", {7'd0, frame_err}, 8'h00);
      check("rst_rx_busy", {7'd0, rx_busy}, 8'h00);
      rst_n = 1'b1;
      idle(2 * CPB);

      // 8N1 0x05
      set_cfg(1'b0, 1'b0, 2'b11, 1'b0);
      push(8'h05, 1'b0, 1'b0);
      send_frame(8'h05, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0);
      wait_drain(4 * CPB);
      idle(CPB);

      // 7E1 0x5A with wrong parity bit
      set_cfg(1'b1, 1'b0, 2'b10, 1'b0);
      push(8'h5A, 1'b1, 1'b0);
      send_frame(8'h5A, 7, 1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b0);
      wait_drain(4 * CPB);
      idle(CPB);

      // 6O1 0x2B, correct parity, config scrambled mid-frame
      set_cfg(1'b1, 1'b1, 2'b01, 1'b0);
      push(8'h2B, 1'b0, 1'b0);
      send_frame(8'h2B, 6, 1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b1);
      wait_drain(4 * CPB);
      idle(CPB);

      // 5O2 0x1F, second stop low -> frame error then break
      set_cfg(1'b1, 1'b1, 2'b00, 1'b1);
      push(8'h1F, 1'b0, 1'b1);
      send_frame(8'h1F, 5, 1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b0);
      wait_drain(4 * CPB);
      repeat (20 * CPB) @(negedge clk);
      check("break_busy", {7'd0, rx_busy}, 8'h01);
      sin = 1'b1;
      repeat (6) @(negedge clk);
      check("break_exit_busy", {7'd0, rx_busy}, 8'h00);
      idle(CPB);

      // Start glitch: low 4 clocks
      @(negedge clk);
      sin = 1'b0;
      repeat (4) @(negedge clk);
      sin = 1'b1;
      repeat (2) @(negedge clk);
      check("glitch_busy_high", {7'd0, rx_busy}, 8'h01);
      repeat (8) @(negedge clk);
      check("glitch_busy_low", {7'd0, rx_busy}, 8'h00);
      idle(2 * CPB);

      // Reset mid-frame of 0xA5 while line is low, then 0x3C
      set_cfg(1'b0, 1'b0, 2'b11, 1'b0);
      drive_bit(1'b0);
      drive_bit(1'b1);
      @(negedge clk);
      sin = 1'b0;
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check("abort_data_out", data_out, 8'h00);
      check("abort_parity_err", {7'd0, parity_err}, 8'h00);
      check("abort_frame_err", {7'd0, frame_err}, 8'h00);
      check("abort_busy", {7'd0, rx_busy}, 8'h00);
      idle(3 * CPB);
      push(8'h3C, 1'b0, 1'b0);
      send_frame(8'h3C, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0);
      wait_drain(4 * CPB);
      idle(CPB);

      // Back-to-back 0x00 then 0xFF
      vt.delete();
      push(8'h00, 1'b0, 1'b0);
      push(8'hFF, 1'b0, 1'b0);
      send_frame(8'h00, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0);
      send_frame(8'hFF, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0);
      wait_drain(4 * CPB);
      idle(CPB);
      check("b2b_pulse_count", 8'(vt.size()), 8'd2);
      if (vt.size() == 2) begin
         check("b2b_spacing", 8'(vt[1] - vt[0]), 8'(10 * CPB));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
